cpu_clk_ctrl: RTL

Run/step/halt controller that consumes the slow square wave from the clock divider and turns it into single-cycle clock-enable pulses for the CPU datapath, which stays on the fast system clock iClk. It synchronises the slow clock into the iClk domain and edge-detects it. It debounces the front-panel run switch and step button, and applies the CPU halt request, so the design can free-run at the divided rate, single-step, or stop.

---
 rtl/clk_ctrl_pkg.sv | 13 +
 rtl/cpu_clk_ctrl_debounce.sv | 50 +++++
 rtl/cpu_clk_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the CPU clock controller: FSM encodings and counter width.
package clk_ctrl_pkg;

  localparam int unsigned CYCLES_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } ctrlState_t;

endpackage

// File: rtl/cpu_clk_ctrl_debounce.sv
// Synchroniser plus stable-count debouncer for a front-panel input.
// oLevel follows iRaw after it holds a new value; oRise pulses on a debounced 0->1 change.
module debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic iClk,
  input  logic nRst,
  input  logic iRaw,
  output logic oLevel,
  output logic oRise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] syncQ;
  logic [CNT_W-1:0]       cnt;
  logic                   syncIn;

  assign syncIn = syncQ[SYNC_STAGES-1];

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      syncQ <= '0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], iRaw};
    end
  end

  // Count consecutive cycles that disagree with the current level; any agreement restarts.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      cnt    <= '0;
      oLevel <= 1'b0;
      oRise  <= 1'b0;
    end else if (syncIn == oLevel) begin
      cnt   <= '0;
      oRise <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt    <= '0;
      oLevel <= syncIn;
      oRise  <= syncIn;
    end else begin
      cnt   <= cnt + CNT_W'(1);
      oRise <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller: turns the divided slow clock into single-cycle CPU
// clock enables on iClk, gated by debounced run/step inputs and the halt request.
module cpu_clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                iClk,
  input  logic                nRst,
  input  logic                iSlowClk,
  input  logic                iRun,
  input  logic                iStep,
  input  logic                iHalt,
  output logic                oEn,
  output logic                oRunning,
  output logic                oHalted,
  output logic [CYCLES_W-1:0] oCycles
);

  logic [SYNC_STAGES-1:0] slowSync;
  logic                   slowPrev;
  logic                   tick;
  logic                   runLvl;
  logic                   stepLvl;
  logic                   stepPress;
  logic                   unusedRunRise;
  logic                   unusedStepLvl;
  logic                   enNext;
  logic [CYCLES_W-1:0]    cycleCnt;
  ctrlState_t             state;
  ctrlState_t             stateNext;

  assign unusedStepLvl = stepLvl;
  assign oCycles       = cycleCnt;

  // Slow clock synchroniser with a registered rising-edge tick.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      slowSync <= '0;
      slowPrev <= 1'b0;
      tick     <= 1'b0;
    end else begin
      slowSync <= {slowSync[SYNC_STAGES-2:0], iSlowClk};
      slowPrev <= slowSync[SYNC_STAGES-1];
      tick     <= slowSync[SYNC_STAGES-1] & ~slowPrev;
    end
  end

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) uRunDb (
    .iClk  (iClk),
    .nRst  (nRst),
    .iRaw  (iRun),
    .oLevel(runLvl),
    .oRise (unusedRunRise)
  );

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) uStepDb (
    .iClk  (iClk),
    .nRst  (nRst),
    .iRaw  (iStep),
    .oLevel(stepLvl),
    .oRise (stepPress)
  );

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Halt has priority everywhere; a press arriving outside IDLE is dropped.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (iHalt)          stateNext = HALTED;
        else if (runLvl)    stateNext = RUN;
        else if (stepPress) stateNext = STEP;
      end
      RUN: begin
        if (iHalt)        stateNext = HALTED;
        else if (!runLvl) stateNext = IDLE;
      end
      STEP: begin
        if (iHalt)     stateNext = HALTED;
        else if (tick) stateNext = IDLE;
      end
      HALTED: begin
        if (!iHalt && !runLvl) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    enNext = 1'b0;
    unique case (state)
      RUN:     enNext = tick & ~iHalt & runLvl;
      STEP:    enNext = tick & ~iHalt;
      default: enNext = 1'b0;
    endcase
  end

  // Registered outputs; status flags trail the state register by one edge.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oEn      <= 1'b0;
      oRunning <= 1'b0;
      oHalted  <= 1'b0;
      cycleCnt <= '0;
    end else begin
      oEn      <= enNext;
      oRunning <= (state == RUN);
      oHalted  <= (state == HALTED);
      cycleCnt <= cycleCnt + CYCLES_W'(oEn);
    end
  end

endmodule
